// File: rtl/data_bus_responder_pkg.sv
// Shared constants, conf-window decode and byte-merge helper for data_bus_responder.
// The optional access counters are enabled by the DBUS_ACCESS_COUNT_EN macro.
package data_bus_responder_pkg;

    localparam logic [31:0] CONF_BASE_DEF = 32'hbfaf_0000;
    localparam logic [31:0] CONF_MASK_DEF = 32'hffff_0000;

    localparam logic [15:0] OFF_CR     = 16'h8000;
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_RDCNT  = 16'he010;
    localparam logic [15:0] OFF_WRCNT  = 16'he014;
    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CR     = 3'd1,
        SEL_TIMER  = 3'd2,
        SEL_LED    = 3'd3,
        SEL_NUM    = 3'd4,
        SEL_SWITCH = 3'd5,
        SEL_RDCNT  = 3'd6,
        SEL_WRCNT  = 3'd7
    } conf_sel_e;

    // Byte offset bits [1:0] are ignored; CR0..CR7 occupy one 32-byte block.
    function automatic conf_sel_e decode_conf(input logic [15:0] off);
        logic [15:0] word_off;
        conf_sel_e   sel;
        word_off = {off[15:2], 2'b00};
        sel      = SEL_NONE;
        if (word_off[15:5] == OFF_CR[15:5]) begin
            sel = SEL_CR;
        end else begin
            case (word_off)
                OFF_TIMER:  sel = SEL_TIMER;
                OFF_RDCNT:  sel = SEL_RDCNT;
                OFF_WRCNT:  sel = SEL_WRCNT;
                OFF_LED:    sel = SEL_LED;
                OFF_NUM:    sel = SEL_NUM;
                OFF_SWITCH: sel = SEL_SWITCH;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  we);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data SRAM bus: core drives en/we/addr/wdata, responder returns rdata a cycle later.
interface data_bus_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_bus_responder_bytewe_sram.sv
// Byte-writable single-port RAM, read-first, one-cycle read latency, contents not reset.
module bytewe_sram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    // Read-first access: the old word is captured while enabled lanes are overwritten.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int k = 0; k < 4; k++) begin
                if (i_we[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: decodes RAM vs. config window, holds conf registers and timer.
// Define DBUS_ACCESS_COUNT_EN to add read/write access counters at e010/e014.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
    parameter logic [31:0] CONF_MASK = CONF_MASK_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    data_bus_responder_if.slave  bus,
    input  logic [7:0]           switch_in,
    output logic [15:0]          led_out,
    output logic [31:0]          num_out
);

    logic        w_en;
    logic        w_wr;
    logic        w_conf_hit;
    logic        w_conf_wr;
    logic        w_ram_en;
    conf_sel_e   w_sel;
    logic [2:0]  w_cr_idx;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_conf_rdata;
    logic [31:0] w_timer_next;
    logic [31:0] w_led_merged;
    logic [31:0] w_num_merged;
    logic [31:0] w_cr_merged;

    logic [31:0] r_cr [0:7];
    logic [31:0] r_timer;
    logic [15:0] r_led;
    logic [31:0] r_num;
    logic        r_sel_ram;
    logic [31:0] r_conf_rdata;

    assign w_en       = bus.data_sram_en;
    assign w_wr       = (bus.data_sram_we != 4'b0000);
    assign w_conf_hit = ((bus.data_sram_addr & CONF_MASK) == CONF_BASE);
    assign w_conf_wr  = w_en & w_conf_hit & w_wr;
    assign w_sel      = decode_conf(bus.data_sram_addr[15:0]);
    assign w_cr_idx   = bus.data_sram_addr[4:2];
    // Reset masks the RAM enable so a request in flight never writes.
    assign w_ram_en   = w_en & ~w_conf_hit & ~reset;

    bytewe_sram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (bus.data_sram_we),
        .i_addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .i_wdata (bus.data_sram_wdata),
        .o_rdata (w_ram_rdata)
    );

`ifdef DBUS_ACCESS_COUNT_EN
    logic [31:0] r_rdcnt;
    logic [31:0] r_wrcnt;

    // Every accepted request bumps one counter; a write to a counter clears it instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdcnt <= 32'd0;
            r_wrcnt <= 32'd0;
        end else if (w_en) begin
            if (w_wr) begin
                if (w_conf_wr && (w_sel == SEL_WRCNT)) begin
                    r_wrcnt <= 32'd0;
                end else begin
                    r_wrcnt <= r_wrcnt + 32'd1;
                end
                if (w_conf_wr && (w_sel == SEL_RDCNT)) begin
                    r_rdcnt <= 32'd0;
                end
            end else begin
                r_rdcnt <= r_rdcnt + 32'd1;
            end
        end
    end
`endif

    // Byte-merged next values for the writable conf registers.
    always_comb begin
        w_led_merged = merge_bytes({16'h0000, r_led}, bus.data_sram_wdata,
                                   {2'b00, bus.data_sram_we[1:0]});
        w_num_merged = merge_bytes(r_num, bus.data_sram_wdata, bus.data_sram_we);
        w_cr_merged  = merge_bytes(r_cr[w_cr_idx], bus.data_sram_wdata, bus.data_sram_we);
        if (w_conf_wr && (w_sel == SEL_TIMER)) begin
            w_timer_next = merge_bytes(r_timer + 32'd1, bus.data_sram_wdata, bus.data_sram_we);
        end else begin
            w_timer_next = r_timer + 32'd1;
        end
    end

    // Conf read mux; the timer is seen before this edge's increment.
    always_comb begin
        w_conf_rdata = 32'h0000_0000;
        case (w_sel)
            SEL_CR:     w_conf_rdata = r_cr[w_cr_idx];
            SEL_TIMER:  w_conf_rdata = r_timer;
            SEL_LED:    w_conf_rdata = {16'h0000, r_led};
            SEL_NUM:    w_conf_rdata = r_num;
            SEL_SWITCH: w_conf_rdata = {24'h00_0000, switch_in};
`ifdef DBUS_ACCESS_COUNT_EN
            SEL_RDCNT:  w_conf_rdata = r_rdcnt;
            SEL_WRCNT:  w_conf_rdata = r_wrcnt;
`endif
            default:    w_conf_rdata = 32'h0000_0000;
        endcase
    end

    // Conf register file and free-running timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'd0;
            r_led   <= 16'h0000;
            r_num   <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                r_cr[i] <= 32'd0;
            end
        end else begin
            r_timer <= w_timer_next;
            if (w_conf_wr) begin
                case (w_sel)
                    SEL_CR:  r_cr[w_cr_idx] <= w_cr_merged;
                    SEL_LED: r_led <= w_led_merged[15:0];
                    SEL_NUM: r_num <= w_num_merged;
                    default: ;
                endcase
            end
        end
    end

    // Response register: remembers the target and the conf value; holds while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_ram    <= 1'b0;
            r_conf_rdata <= 32'd0;
        end else if (w_en) begin
            r_sel_ram    <= ~w_conf_hit;
            r_conf_rdata <= w_conf_hit ? w_conf_rdata : 32'd0;
        end
    end

    assign bus.data_sram_rdata = r_sel_ram ? w_ram_rdata : r_conf_rdata;
    assign led_out             = r_led;
    assign num_out             = r_num;

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Target-side responder for the CPU data SRAM interface (en / byte-we / addr / wdata out of the core, rdata back into it).
- Decodes each request to one of two targets:
  - local byte-writable RAM;
  - a configuration-register window with a free-running timer, LED register, numeric display register, scratch registers and a switch input.
- Fixed one-cycle read latency, matching what the MEM stage expects.

Parameters:
- RAM_AW, 14: RAM word-address width (2^14 words = 64 KiB).
- CONF_BASE, 32'hbfaf_0000: base address of the config window.
- CONF_MASK, 32'hffff_0000: mask applied to addr when comparing against CONF_BASE.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_we  in  4  byte write enables; 0 means read.
- data_sram_addr  in  32  byte address; bits [1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, valid the cycle after the request.
- switch_in  in  8  board switches (read-only register).
- led_out  out  16  LED register.
- num_out  out  32  numeric display register.

Behaviour:
- Reset (clk edge with reset=1):
  - data_sram_rdata, led_out, num_out, timer and CR0..CR7 all go to 0.
  - RAM contents are not reset.
- Decode: conf_hit = ((addr & CONF_MASK) == CONF_BASE). Otherwise the RAM target is selected, indexed by addr[RAM_AW+1:2]; upper bits are aliased.
- Conf offsets, using addr[15:0]:
  - 8000+4i: CR i, for i = 0..7.
  - e000: TIMER.
  - f000: LED, low 16 bits.
  - f010: NUM.
  - f020: SWITCH, zero-extended, read-only.
  - Any other offset reads 0; writes to it are dropped.
- Write (en=1, we!=0):
  - Each byte lane k is updated iff we[k].
  - LED takes lanes 0-1 only.
  - Writes to SWITCH are ignored.
  - The write commits at this clock edge.
- Read (en=1, we=0): data_sram_rdata is registered at this edge and shows the target value in the next cycle.
- Write cycles are read-first: rdata is loaded with the target's pre-write value. The core ignores it.
- en=0: rdata holds its previous value.
- Back-to-back write to address A in cycle N, then read of A in cycle N+1: rdata in N+2 shows the new data.
- Timer:
  - Increments by 1 every cycle and wraps from 32'hffffffff to 0.
  - If a TIMER write and the increment occur in the same cycle, the written bytes win and unwritten bytes take the incremented value.
  - A TIMER read returns the value before this edge's increment.
- Reset mid-request: reset has priority. The request is discarded, rdata is 0 in the following cycle, and there is no RAM write.
- No stall or backpressure: the block accepts one request per cycle.

Optional Feature:
- Macro: DBUS_ACCESS_COUNT_EN.
- Defined:
  - Adds 32-bit read and write counters, reset to 0, which wrap.
  - The counters count every accepted request (en=1), RAM and conf alike.
  - Readable at e010 (reads) and e014 (writes); writes to these addresses clear the addressed counter.
  - A request that accesses a counter is itself counted after the read value is sampled.
- Not defined: e010 and e014 behave as unmapped (read 0, writes dropped). No counter flops.

Decomposition:
- Shared constants header: CONF_BASE default, the offsets for CR/TIMER/LED/NUM/SWITCH/RDCNT/WRCNT, and the conf-select encoding.
- Sub-module: bytewe_sram. Parameterised by address width; synchronous read-first, 4 byte-lane enables, 1-cycle latency.
- The responder holds the decode, the conf registers and the registered output mux.

Test Plan:
- RAM read-after-write:
  - Stimulus: write 32'h12345678 with we=4'hf to 0x0000_0040, then the next cycle read 0x40.
  - Required: rdata = 32'h12345678 one cycle after the read.
- Byte lanes:
  - Stimulus: write 32'haabbccdd with we=4'b0101 to a word previously holding 32'h0, then read it.
  - Required: rdata = 32'h00bb00dd.
- Conf registers:
  - Stimulus: write 32'h0000_5a5a to bfaf_f000, then 32'hdeadbeef to bfaf_f010; read CR3 after writing 7.
  - Required: led_out = 16'h5a5a, num_out = 32'hdeadbeef, CR3 reads 7.
  - Stimulus: read bfaf_f020 with switch_in=8'h3c. Required: rdata = 32'h3c.
- Timer:
  - Stimulus: release reset, idle 10 cycles, read TIMER.
  - Required: value increments by the cycle count.
  - Stimulus: write 32'hffff_fffe and read across the wrap. Required: values fffffffe → ffffffff → 0.
- Reset and idle:
  - Stimulus: assert reset during a RAM write.
  - Required: the write is dropped and rdata = 0.
  - Stimulus: hold en=0 for 5 cycles after a read. Required: rdata stays stable.
  - Stimulus: read unmapped bfaf_1234. Required: rdata = 0.
- With DBUS_ACCESS_COUNT_EN:
  - Stimulus: 3 reads, 2 writes, then read e010.
  - Required: rdata = 3, and e014 reads 2.
  - Stimulus: same sequence with the macro undefined. Required: both addresses read 0.
